// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    STROBE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

  localparam int DEF_MAX_BURST   = 16;
  localparam int DEF_ACK_TIMEOUT = 15;
  localparam int BURST_W         = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter side signals of the UART arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]              req_last;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            uart_tx_en;
  logic [PAYLOAD_BITS-1:0]         uart_tx_data;
  logic                            uart_tx_busy;
  logic [IW-1:0]                   grant_id;
  logic                            grant_active;
  logic                            ack_err;

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_tx_en, uart_tx_data, grant_id, grant_active, ack_err
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_tx_en, uart_tx_data, grant_id, grant_active, ack_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above 'last', wrapping, 'last' itself checked last.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic [IW-1:0] c;
    found = 1'b0;
    idx   = last;
    c     = '0;
    for (int k = 1; k <= N; k++) begin
      c = IW'((int'(last) + k) % N);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding one UART transmitter. A grant is held for a whole
// packet (capped at MAX_BURST bytes); each byte is strobed and then tracked through busy.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input logic              clk,
  input logic              rstn,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]      TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);
  localparam logic [IW-1:0]      RST_ID    = IW'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [IW-1:0]           grant_id_q, grant_id_d;
  logic                    grant_active_q, grant_active_d;
  logic [BURST_W-1:0]      burst_q, burst_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    last_q, last_d;

  logic                    pick_found;
  logic [IW-1:0]           pick_idx;
  logic                    cur_valid, cur_last;
  logic [PAYLOAD_BITS-1:0] cur_data;
  logic                    accept, timeout, release_done;
  logic [NUM_REQ-1:0]      req_ready_c;
  logic                    tx_en_c, ack_err_c;

  // grant_id_q doubles as the last-grant pointer once the grant is released
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (bus.req_valid),
    .last  (grant_id_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cur_valid = bus.req_valid[grant_id_q];
  assign cur_last  = bus.req_last[grant_id_q];
  assign cur_data  = bus.req_data[int'(grant_id_q)*PAYLOAD_BITS +: PAYLOAD_BITS];

  assign accept       = (state_q == ISSUE) && cur_valid && !bus.uart_tx_busy;
  assign timeout      = (state_q == WAIT_BUSY) && !bus.uart_tx_busy && (tmo_q == TMO_LAST);
  assign release_done = (state_q == WAIT_DONE) && !bus.uart_tx_busy &&
                        (last_q || (burst_q == BURST_LIM));

  // state register and datapath flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      grant_id_q     <= RST_ID;
      grant_active_q <= 1'b0;
      burst_q        <= '0;
      tmo_q          <= '0;
      data_q         <= '0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      burst_q        <= burst_d;
      tmo_q          <= tmo_d;
      data_q         <= data_d;
      last_q         <= last_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (pick_found) state_d = ISSUE;
      ISSUE:     if (accept) state_d = STROBE;
      STROBE:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.uart_tx_busy) state_d = WAIT_DONE;
        else if (timeout)     state_d = IDLE;
      end
      WAIT_DONE: begin
        if (release_done)           state_d = IDLE;
        else if (!bus.uart_tx_busy) state_d = ISSUE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // datapath next values
  always_comb begin
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    burst_d        = burst_q;
    tmo_d          = tmo_q;
    data_d         = data_q;
    last_d         = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d     = pick_idx;
          grant_active_d = 1'b1;
          burst_d        = '0;
        end
      end
      ISSUE: begin
        if (accept) begin
          data_d  = cur_data;
          last_d  = cur_last;
          burst_d = (burst_q == BURST_LIM) ? burst_q : burst_q + 1'b1;
        end
      end
      STROBE:    tmo_d = '0;
      WAIT_BUSY: begin
        if (timeout)                grant_active_d = 1'b0;
        else if (!bus.uart_tx_busy) tmo_d = tmo_q + 1'b1;
      end
      WAIT_DONE: if (release_done) grant_active_d = 1'b0;
      default: ;
    endcase
  end

  // outputs
  always_comb begin
    req_ready_c = '0;
    if (accept) req_ready_c[grant_id_q] = 1'b1;
    tx_en_c   = (state_q == STROBE);
    ack_err_c = timeout;
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.uart_tx_en   = tx_en_c;
  assign bus.ack_err      = ack_err_c;
  assign bus.uart_tx_data = data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_active = grant_active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester sources, a randomized busy responder,
// and a packet-level round-robin model for expected transmit order.
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int PB  = 8;
  localparam int MB  = 16;
  localparam int AT  = 15;
  localparam int IWT = $clog2(NR);
  localparam logic [IWT-1:0] RST_ID = IWT'(NR - 1);

  typedef struct {
    int         id;
    logic [7:0] data;
  } ev_t;

  logic clk;
  logic rstn;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .PAYLOAD_BITS(PB)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .PAYLOAD_BITS(PB), .MAX_BURST(MB), .ACK_TIMEOUT(AT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors;
  int         checks;
  logic [7:0] src_d[NR][$];
  bit         src_l[NR][$];
  ev_t        log_q[$];
  int         exp_id[$];
  logic [7:0] exp_dat[$];
  bit         mute;
  int         ready_viol;
  int         en_viol;

  // requester sources: present queue heads, pop on accepted bytes
  initial begin
    logic [NR-1:0] pop;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      pop = bus.req_ready;
      if (rstn && bus.req_ready != '0) begin
        if (!bus.grant_active || $countones(bus.req_ready) != 1 ||
            !bus.req_ready[bus.grant_id] || !bus.req_valid[bus.grant_id])
          ready_viol++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (pop[i] && rstn && src_d[i].size() > 0) begin
          void'(src_d[i].pop_front());
          void'(src_l[i].pop_front());
        end
      end
      for (int i = 0; i < NR; i++) begin
        bus.req_valid[i]       = (src_d[i].size() > 0);
        bus.req_data[i*PB +: PB] = (src_d[i].size() > 0) ? src_d[i][0] : 8'h00;
        bus.req_last[i]        = (src_d[i].size() > 0) ? src_l[i][0] : 1'b0;
      end
    end
  end

  // transmitter: log every strobe, then raise busy after 0..3 cycles for 1..4 cycles
  initial begin
    int wait_c, hold_c;
    bit pend, prev_en;
    wait_c = 0; hold_c = 0; pend = 0; prev_en = 0;
    bus.uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.uart_tx_en === 1'b1) begin
        ev_t e;
        e.id   = int'(bus.grant_id);
        e.data = bus.uart_tx_data;
        log_q.push_back(e);
        if (prev_en) en_viol++;
        if (!mute) begin
          pend   = 1;
          wait_c = int'($urandom_range(0, 3));
          hold_c = int'($urandom_range(1, 4));
        end
      end
      prev_en = (bus.uart_tx_en === 1'b1);
      @(posedge clk);
      #1;
      if (!rstn) begin
        pend = 0;
        bus.uart_tx_busy = 1'b0;
      end else if (pend) begin
        if (wait_c == 0) begin
          pend = 0;
          bus.uart_tx_busy = 1'b1;
        end else wait_c--;
      end else if (bus.uart_tx_busy) begin
        if (hold_c <= 1) bus.uart_tx_busy = 1'b0;
        else hold_c--;
      end
    end
  end

  task automatic push_byte(input int id, input logic [7:0] d, input bit l);
    src_d[id].push_back(d);
    src_l[id].push_back(l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    mute = 0;
    for (int i = 0; i < NR; i++) begin
      src_d[i].delete();
      src_l[i].delete();
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    log_q.delete();
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (log_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (30) @(negedge clk);
  endtask

  // packet-level round robin from a fresh reset: whole packets, capped at MB bytes per grant
  task automatic model_sched();
    logic [7:0] md[NR][$];
    bit         ml[NR][$];
    int         cur, pick, cnt;
    bit         stop, done, l;
    exp_id.delete();
    exp_dat.delete();
    for (int i = 0; i < NR; i++) begin
      md[i] = src_d[i];
      ml[i] = src_l[i];
    end
    cur = NR - 1;
    stop = 0;
    while (!stop) begin
      pick = -1;
      for (int k = 1; k <= NR; k++)
        if (pick < 0 && md[(cur + k) % NR].size() > 0) pick = (cur + k) % NR;
      if (pick < 0) stop = 1;
      else begin
        cur = pick; cnt = 0; done = 0;
        while (!done && !stop) begin
          if (md[pick].size() == 0) stop = 1;  // open packet keeps the grant forever
          else begin
            exp_id.push_back(pick);
            exp_dat.push_back(md[pick].pop_front());
            l = ml[pick].pop_front();
            cnt++;
            done = l || (cnt == MB);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.uart_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b expected 0", bus.uart_tx_en); end
    checks++; if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.uart_tx_data); end
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
    checks++; if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL reset_grant_active: got %b expected 0", bus.grant_active); end
    checks++; if (bus.grant_id !== RST_ID) begin errors++; $display("FAIL reset_grant_id: got %0d expected %0d", bus.grant_id, RST_ID); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b expected 0", bus.ack_err); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_packet();
    logic [7:0] want[3];
    want[0] = 8'h41; want[1] = 8'h42; want[2] = 8'h43;
    do_reset();
    push_byte(0, 8'h41, 0);
    push_byte(0, 8'h42, 0);
    push_byte(0, 8'h43, 1);
    wait_log(3, 300);
    checks++;
    if (log_q.size() != 3) begin errors++; $display("FAIL single_count: got %0d strobes expected 3", log_q.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= log_q.size() || log_q[k].id != 0 || log_q[k].data !== want[k]) begin
        errors++;
        $display("FAIL single_byte%0d: got id %0d data %h expected id 0 data %h", k,
                 (k < log_q.size()) ? log_q[k].id : -1, (k < log_q.size()) ? log_q[k].data : 8'hxx, want[k]);
      end
    end
    checks++;
    if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL single_release: got grant_active %b expected 0", bus.grant_active); end
  endtask

  task automatic test_alternate();
    int         wid[4];
    logic [7:0] wd[4];
    wid[0] = 0; wid[1] = 2; wid[2] = 0; wid[3] = 2;
    wd[0] = 8'h10; wd[1] = 8'h20; wd[2] = 8'h11; wd[3] = 8'h21;
    do_reset();
    push_byte(0, 8'h10, 1);
    push_byte(0, 8'h11, 1);
    push_byte(2, 8'h20, 1);
    push_byte(2, 8'h21, 1);
    wait_log(4, 300);
    checks++;
    if (log_q.size() != 4) begin errors++; $display("FAIL alt_count: got %0d strobes expected 4", log_q.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= log_q.size() || log_q[k].id != wid[k] || log_q[k].data !== wd[k]) begin
        errors++;
        $display("FAIL alt_grant%0d: got id %0d data %h expected id %0d data %h", k,
                 (k < log_q.size()) ? log_q[k].id : -1, (k < log_q.size()) ? log_q[k].data : 8'hxx, wid[k], wd[k]);
      end
    end
  endtask

  task automatic test_burst_limit();
    do_reset();
    for (int b = 1; b <= 20; b++) push_byte(1, 8'(b), 0);
    push_byte(3, 8'hC1, 0);
    push_byte(3, 8'hC2, 1);
    model_sched();
    wait_log(exp_id.size(), 2000);
    checks++;
    if (log_q.size() != exp_id.size()) begin errors++; $display("FAIL burst_count: got %0d strobes expected %0d", log_q.size(), exp_id.size()); end
    for (int k = 0; k < exp_id.size(); k++) begin
      checks++;
      if (k >= log_q.size() || log_q[k].id != exp_id[k] || log_q[k].data !== exp_dat[k]) begin
        errors++;
        $display("FAIL burst_byte%0d: got id %0d data %h expected id %0d data %h", k,
                 (k < log_q.size()) ? log_q[k].id : -1, (k < log_q.size()) ? log_q[k].data : 8'hxx, exp_id[k], exp_dat[k]);
      end
    end
    checks++;
    if (log_q.size() < 19 || log_q[16].id != 3 || log_q[18].id != 1 || log_q[18].data !== 8'd17) begin
      errors++;
      $display("FAIL burst_handover: got %0d strobes, byte16 id %0d, byte18 id %0d data %h expected 3 / 1 / 11",
               log_q.size(), (log_q.size() > 16) ? log_q[16].id : -1,
               (log_q.size() > 18) ? log_q[18].id : -1, (log_q.size() > 18) ? log_q[18].data : 8'hxx);
    end
    checks++;
    if (bus.grant_active !== 1'b1 || bus.grant_id !== IWT'(1)) begin
      errors++;
      $display("FAIL burst_lock: got active %b id %0d expected active 1 id 1", bus.grant_active, bus.grant_id);
    end
  endtask

  task automatic test_ack_timeout();
    int t_en, t_ack, n_en, n_ack;
    do_reset();
    mute = 1;
    push_byte(0, 8'h5A, 1);
    t_en = -1; t_ack = -1; n_en = 0; n_ack = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.uart_tx_en === 1'b1) begin n_en++; if (t_en < 0) t_en = c; end
      if (bus.ack_err === 1'b1) begin n_ack++; if (t_ack < 0) t_ack = c; end
    end
    checks++;
    if (n_ack != 1 || n_en != 1) begin errors++; $display("FAIL ack_pulses: got %0d ack_err %0d strobes expected 1 and 1", n_ack, n_en); end
    checks++;
    if (t_en < 0 || t_ack < 0 || t_ack - t_en != AT) begin
      errors++;
      $display("FAIL ack_delay: got %0d cycles from strobe expected %0d", t_ack - t_en, AT);
    end
    checks++;
    if (bus.grant_active !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL ack_release: got active %b ready %b expected 0 and 0", bus.grant_active, bus.req_ready);
    end
    mute = 0;
    push_byte(0, 8'h01, 1);
    push_byte(1, 8'h02, 1);
    wait_log(3, 300);
    checks++;
    if (log_q.size() != 3 || log_q[1].id != 1 || log_q[2].id != 0) begin
      errors++;
      $display("FAIL ack_next_owner: got %0d strobes, next ids %0d,%0d expected 3 strobes, ids 1,0", log_q.size(),
               (log_q.size() > 1) ? log_q[1].id : -1, (log_q.size() > 2) ? log_q[2].id : -1);
    end
  endtask

  task automatic test_reset_mid();
    int c, n_en;
    do_reset();
    for (int b = 0; b < 4; b++) push_byte(0, 8'hA0 + 8'(b), b == 3);
    c = 0;
    while (log_q.size() < 2 && c < 300) begin @(negedge clk); c++; end
    c = 0;
    while (bus.uart_tx_busy !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    @(posedge clk);
    #2;
    checks++;
    if (log_q.size() != 2 || bus.grant_active !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: got %0d strobes active %b expected 2 strobes active 1", log_q.size(), bus.grant_active);
    end
    rstn = 1'b0;
    #1;
    checks++; if (bus.uart_tx_en !== 1'b0 || bus.req_ready !== '0 || bus.ack_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_strobes: got en %b ready %b ack %b expected 0 0 0", bus.uart_tx_en, bus.req_ready, bus.ack_err); end
    checks++; if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", bus.uart_tx_data); end
    checks++; if (bus.grant_active !== 1'b0 || bus.grant_id !== RST_ID) begin
      errors++; $display("FAIL rstmid_grant: got active %b id %0d expected 0 and %0d", bus.grant_active, bus.grant_id, RST_ID); end
    for (int i = 0; i < NR; i++) begin
      src_d[i].delete();
      src_l[i].delete();
    end
    n_en = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.uart_tx_en === 1'b1) n_en++;
    end
    push_byte(1, 8'h11, 1);
    push_byte(0, 8'h22, 1);
    rstn = 1'b1;
    checks++;
    if (n_en != 0 || log_q.size() != 2) begin errors++; $display("FAIL rstmid_quiet: got %0d strobes in reset, log %0d expected 0 and 2", n_en, log_q.size()); end
    wait_log(4, 300);
    checks++;
    if (log_q.size() != 4 || log_q[2].id != 0 || log_q[2].data !== 8'h22 || log_q[3].id != 1) begin
      errors++;
      $display("FAIL rstmid_priority: got %0d strobes, first owner %0d expected 4 strobes, owner 0 then 1", log_q.size(),
               (log_q.size() > 2) ? log_q[2].id : -1);
    end
  endtask

  task automatic test_packet_lock();
    int c, n_rdy2;
    do_reset();
    push_byte(0, 8'h31, 0);
    c = 0;
    while (log_q.size() < 1 && c < 200) begin @(negedge clk); c++; end
    push_byte(2, 8'h77, 1);
    n_rdy2 = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_ready[2] === 1'b1) n_rdy2++;
    end
    checks++;
    if (n_rdy2 != 0) begin errors++; $display("FAIL lock_ready2: got %0d ready cycles expected 0", n_rdy2); end
    checks++;
    if (bus.grant_active !== 1'b1 || bus.grant_id !== IWT'(0) || log_q.size() != 1) begin
      errors++;
      $display("FAIL lock_hold: got active %b id %0d strobes %0d expected 1, 0, 1", bus.grant_active, bus.grant_id, log_q.size());
    end
    push_byte(0, 8'h32, 1);
    wait_log(3, 300);
    checks++;
    if (log_q.size() != 3 || log_q[1].id != 0 || log_q[1].data !== 8'h32 || log_q[2].id != 2 || log_q[2].data !== 8'h77) begin
      errors++;
      $display("FAIL lock_order: got %0d strobes, ids %0d,%0d expected 3 strobes, 0 (32) then 2 (77)", log_q.size(),
               (log_q.size() > 1) ? log_q[1].id : -1, (log_q.size() > 2) ? log_q[2].id : -1);
    end
  endtask

  task automatic test_random();
    int npk, len, tot;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < NR; i++) begin
        npk = int'($urandom_range(0, 3));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 20));
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
        end
      end
      if (src_d[0].size() + src_d[1].size() + src_d[2].size() + src_d[3].size() == 0) push_byte(0, 8'hE5, 1);
      model_sched();
      tot = exp_id.size();
      wait_log(tot, tot * 25 + 200);
      checks++;
      if (log_q.size() != tot) begin errors++; $display("FAIL rand%0d_count: got %0d strobes expected %0d", r, log_q.size(), tot); end
      for (int k = 0; k < tot; k++) begin
        checks++;
        if (k >= log_q.size() || log_q[k].id != exp_id[k] || log_q[k].data !== exp_dat[k]) begin
          errors++;
          $display("FAIL rand%0d_byte%0d: got id %0d data %h expected id %0d data %h", r, k,
                   (k < log_q.size()) ? log_q[k].id : -1, (k < log_q.size()) ? log_q[k].data : 8'hxx, exp_id[k], exp_dat[k]);
        end
      end
      checks++;
      if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL rand%0d_idle: got grant_active %b expected 0", r, bus.grant_active); end
    end
  endtask

  initial begin
    errors = 0; checks = 0; mute = 0; ready_viol = 0; en_viol = 0;
    rstn = 1'b0;
    test_reset();
    test_single_packet();
    test_alternate();
    test_burst_limit();
    test_ack_timeout();
    test_reset_mid();
    test_packet_lock();
    test_random();
    checks++;
    if (ready_viol != 0) begin errors++; $display("FAIL ready_legal: got %0d illegal ready cycles expected 0", ready_viol); end
    checks++;
    if (en_viol != 0) begin errors++; $display("FAIL strobe_width: got %0d back-to-back strobes expected 0", en_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter PAYLOAD_BITS, default 8, byte width.
REQ-003 SHALL have parameter MAX_BURST, default 16, max bytes per grant (1..255).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 15, cycles allowed for uart_tx_busy to rise after uart_tx_en.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester byte available.
REQ-008 SHALL have port req_data  in  NUM_REQ*PAYLOAD_BITS  packed bytes; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-009 SHALL have port req_last  in  NUM_REQ  current byte ends the packet.
REQ-010 SHALL have port req_ready  out  NUM_REQ  byte accepted (one-hot or zero).
REQ-011 SHALL have port uart_tx_en  out  1  one-cycle send strobe to the transmitter.
REQ-012 SHALL have port uart_tx_data  out  PAYLOAD_BITS  byte to the transmitter.
REQ-013 SHALL have port uart_tx_busy  in  1  transmitter busy.
REQ-014 SHALL have port grant_id  out  $clog2(NUM_REQ)  current/last owner.
REQ-015 SHALL have port grant_active  out  1  a grant is held.
REQ-016 SHALL have port ack_err  out  1  one-cycle pulse on ACK timeout.

Function
REQ-017 SHALL use FSM states IDLE, ISSUE, STROBE, WAIT_BUSY, WAIT_DONE.
REQ-018 In IDLE, if any req_valid is high, SHALL grant the first valid requester searching upward from (last grant + 1) modulo NUM_REQ, load grant_id, assert grant_active, clear burst count, and go to ISSUE next cycle.
REQ-019 After reset, last grant SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-020 In ISSUE, when req_valid[grant_id]=1 and uart_tx_busy=0, SHALL assert req_ready[grant_id] combinationally that cycle, latch the byte into uart_tx_data and req_last into a last flag, increment burst count, and go to STROBE.
REQ-021 In ISSUE with req_valid[grant_id]=0, SHALL hold the grant indefinitely (packet lock); other requesters SHALL wait.
REQ-022 In STROBE, SHALL drive uart_tx_en=1 for exactly one cycle, then go to WAIT_BUSY; uart_tx_en SHALL be 0 in all other states.
REQ-023 In WAIT_BUSY, uart_tx_busy=1 SHALL move to WAIT_DONE; if ACK_TIMEOUT cycles elapse first, SHALL pulse ack_err, release the grant, and go to IDLE.
REQ-024 In WAIT_DONE, on uart_tx_busy=0: if the last flag is set or burst count equals MAX_BURST, SHALL release (grant_active=0, last grant = grant_id) and go to IDLE; otherwise SHALL return to ISSUE.
REQ-025 Release SHALL take effect so that a new arbitration occurs in the IDLE cycle following release; the released requester SHALL NOT win if any other requester is valid.
REQ-026 uart_tx_data SHALL remain stable from the STROBE cycle until the next ISSUE acceptance.
REQ-027 Burst count SHALL be 8 bits and SHALL saturate at MAX_BURST without wrapping.
REQ-028 req_ready SHALL never assert for a non-granted requester or outside ISSUE.

Reset
REQ-029 On rstn low, SHALL immediately enter IDLE with uart_tx_en=0, uart_tx_data=0, req_ready=0, grant_active=0, grant_id=NUM_REQ-1, ack_err=0, and burst/timeout counters at 0.
REQ-030 Reset mid-transfer SHALL abort without issuing further strobes; the partially sent packet SHALL NOT be resumed.

Structure
REQ-031 A shared package uart_arb_pkg SHALL hold the state enumeration and the default MAX_BURST/ACK_TIMEOUT constants.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, last grant; outputs: found, index), combinational.

Verification
REQ-033 Single requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> exactly 3 uart_tx_en pulses, data in order, then grant_active=0.
REQ-034 Requesters 0 and 2 both valid with 1-byte packets, repeated -> grant order 0,2,0,2; never two grants in a row to one while the other is valid.
REQ-035 Requester 1 streams 20 bytes with no last, MAX_BURST=16 -> release after byte 16, requester 3 (valid) served next, then requester 1 resumes at byte 17.
REQ-036 uart_tx_busy held 0 after strobe -> ack_err pulses once 15 cycles later, grant released, FSM in IDLE.
REQ-037 rstn asserted during WAIT_DONE of byte 2 of 4 -> all outputs at reset values immediately, no further uart_tx_en; after release, requester 0 wins first.
REQ-038 Granted requester drops req_valid for 50 cycles mid-packet while requester 2 is valid -> no req_ready to requester 2 until the packet's last byte completes.
